// File: rtl/lcd_msg_arbiter_if.sv
// Bundle between message requesters, the arbiter and the LCD bus interface.
// Carries per-requester request/grant/ack, both 16-char lines, and the LCD start/done handshake.
interface lcd_msg_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]             I_REQ;
    logic [NREQ-1:0][0:15][7:0]  I_MSG0;
    logic [NREQ-1:0][0:15][7:0]  I_MSG1;
    logic [NREQ-1:0]             O_GNT;
    logic [NREQ-1:0]             O_ACK;
    logic                        O_BUSY;
    logic                        O_TIMEOUT;
    logic                        O_LCD_START;
    logic [0:15][7:0]            O_LCD_WDATA0;
    logic [0:15][7:0]            O_LCD_WDATA1;
    logic                        I_LCD_DONE;

    modport master (
        output I_REQ, I_MSG0, I_MSG1, I_LCD_DONE,
        input  O_GNT, O_ACK, O_BUSY, O_TIMEOUT, O_LCD_START, O_LCD_WDATA0, O_LCD_WDATA1
    );

    modport slave (
        input  I_REQ, I_MSG0, I_MSG1, I_LCD_DONE,
        output O_GNT, O_ACK, O_BUSY, O_TIMEOUT, O_LCD_START, O_LCD_WDATA0, O_LCD_WDATA1
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one 2x16 LCD bus interface among NREQ message sources.
// Grant+data 1 cycle after request sampled, start 1 cycle later; requesters hold I_REQ until O_ACK.
module lcd_msg_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYC    = 1024,
    parameter int TIMEOUT_CYC = 262144
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    lcd_msg_arbiter_if.slave    bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);
    localparam logic [0:15][7:0] BLANK  = {16{8'h20}};

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_HOLD
    } state_t;

    state_t             state_q, state_nxt;
    logic [PW-1:0]      ptr_q, ptr_nxt;
    logic [PW-1:0]      win_q, win_nxt;
    logic [NREQ-1:0]    gnt_q, gnt_nxt;
    logic [NREQ-1:0]    ack_q, ack_nxt;
    logic               start_q, start_nxt;
    logic               to_q, to_nxt;
    logic               busy_q;
    logic [TW-1:0]      wcnt_q, wcnt_nxt;
    logic [HW-1:0]      hcnt_q, hcnt_nxt;
    logic [0:15][7:0]   buf0_q, buf1_q;
    logic               load;
    logic               msg_end;
    logic               rr_found;
    logic [PW-1:0]      rr_win;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin : rr_search
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!rr_found && bus.I_REQ[PW'(idx)]) begin
                rr_found = 1'b1;
                rr_win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        win_nxt   = win_q;
        gnt_nxt   = gnt_q;
        ack_nxt   = '0;
        start_nxt = 1'b0;
        to_nxt    = to_q;
        wcnt_nxt  = wcnt_q;
        hcnt_nxt  = hcnt_q;
        load      = 1'b0;
        msg_end   = 1'b0;
        case (state_q)
            ST_WAIT_INIT: begin
                if (bus.I_LCD_DONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                gnt_nxt = '0;
                if (rr_found) begin
                    win_nxt   = rr_win;
                    gnt_nxt   = onehot(rr_win);
                    load      = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                start_nxt = 1'b1;
                wcnt_nxt  = '0;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                wcnt_nxt = wcnt_q + TW'(1);
                // Done takes priority over a watchdog expiry in the same cycle.
                if (bus.I_LCD_DONE) begin
                    to_nxt  = 1'b0;
                    msg_end = 1'b1;
                end else if (wcnt_q == TO_LAST) begin
                    to_nxt  = 1'b1;
                    msg_end = 1'b1;
                end
                if (msg_end) begin
                    ack_nxt   = onehot(win_q);
                    ptr_nxt   = win_q;
                    hcnt_nxt  = '0;
                    state_nxt = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                gnt_nxt = '0;
                if (hcnt_q == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hcnt_nxt = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_nxt = ST_WAIT_INIT;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= ST_WAIT_INIT;
            ptr_q   <= PTR_RST;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b1;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            win_q   <= win_nxt;
            gnt_q   <= gnt_nxt;
            ack_q   <= ack_nxt;
            start_q <= start_nxt;
            to_q    <= to_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
            wcnt_q  <= wcnt_nxt;
            hcnt_q  <= hcnt_nxt;
        end
    end

    // Line buffers keep the last message on display until the next grant.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            buf0_q <= BLANK;
            buf1_q <= BLANK;
        end else if (load) begin
            buf0_q <= bus.I_MSG0[rr_win];
            buf1_q <= bus.I_MSG1[rr_win];
        end
    end

    assign bus.O_GNT        = gnt_q;
    assign bus.O_ACK        = ack_q;
    assign bus.O_BUSY       = busy_q;
    assign bus.O_TIMEOUT    = to_q;
    assign bus.O_LCD_START  = start_q;
    assign bus.O_LCD_WDATA0 = buf0_q;
    assign bus.O_LCD_WDATA1 = buf1_q;

endmodule

// File: doc/lcd_msg_arbiter.md
Name: lcd_msg_arbiter

Overview:
- Shares the 2x16 character LCD bus interface among NREQ message requesters.
- Waits for the LCD bus interface to finish its power-up initialisation.
- Then, per message: round-robin picks one requester, latches its two 16-byte lines into registered line buffers, pulses start to the LCD bus interface, waits for done, and acknowledges the requester.
- Provides a post-message hold time and a done-timeout watchdog.
- Sits between the application/USB status logic and the LCD bus interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_CYC, 1024, minimum cycles a completed message stays displayed before the next grant; 0 = no hold.
- TIMEOUT_CYC, 262144, max cycles in BUSY waiting for I_LCD_DONE; counter width $clog2(TIMEOUT_CYC+1).

Ports:
- I_CLK  in  1  system clock.
- I_RST  in  1  reset, asynchronous, active-high.
- I_REQ  in  NREQ  per-requester request level; hold until O_ACK.
- I_MSG0  in  [NREQ-1:0][0:15][7:0]  per-requester line 0 characters.
- I_MSG1  in  [NREQ-1:0][0:15][7:0]  per-requester line 1 characters.
- O_GNT  out  NREQ  one-hot grant; high from grant until ack cycle inclusive.
- O_ACK  out  NREQ  one-cycle pulse to the granted requester when its message ends.
- O_BUSY  out  1  high in any state other than IDLE.
- O_TIMEOUT  out  1  sticky; set on watchdog expiry, cleared by the next done-terminated message.
- O_LCD_START  out  1  one-cycle start pulse to the LCD bus interface.
- O_LCD_WDATA0  out  [0:15][7:0]  registered line 0 buffer.
- O_LCD_WDATA1  out  [0:15][7:0]  registered line 1 buffer.
- I_LCD_DONE  in  1  one-cycle done pulse from the LCD bus interface.

Behaviour:
- Reset values: O_GNT=0, O_ACK=0, O_BUSY=1, O_TIMEOUT=0, O_LCD_START=0, all buffer bytes 8'h20 (space). Round-robin pointer ptr=NREQ-1, so requester 0 has first priority. State is WAIT_INIT. All outputs are registered.
- WAIT_INIT: ignore I_REQ. On I_LCD_DONE (end of LCD init), go to IDLE. A request present in that same cycle is granted no earlier than the following cycle.
- IDLE: if |I_REQ, winner w = first set bit searching ptr+1, ptr+2, ... modulo NREQ. On that edge: O_GNT<=onehot(w), O_LCD_WDATA0<=I_MSG0[w], O_LCD_WDATA1<=I_MSG1[w], go to START. Grant and data appear one cycle after the request is sampled.
- START: O_LCD_START<=1 for exactly one cycle (data stable ≥1 cycle before start). Clear the watchdog counter. Go to BUSY.
- BUSY: increment the watchdog each cycle.
  - On I_LCD_DONE: O_ACK[w]<=1 for one cycle, O_TIMEOUT<=0, ptr<=w, O_GNT<=0 on the following edge, go to HOLD.
  - If the counter reaches TIMEOUT_CYC before done: O_TIMEOUT<=1, O_ACK[w] pulse as normal, ptr<=w, go to HOLD.
  - If done and expiry coincide, done wins (O_TIMEOUT cleared).
- HOLD: count HOLD_CYC cycles, then go to IDLE; with HOLD_CYC=0, go straight to IDLE. I_LCD_DONE arriving in HOLD or IDLE (late done after a timeout) is ignored.
- I_REQ deasserted after grant: message already latched; transfer completes and O_ACK still pulses.
- I_REQ still high after ack: treated as a new request; rotation order still applies.
- Line buffers hold their last contents between messages and are never cleared except by reset.
- I_RST mid-operation: immediate return to reset values. The LCD bus interface reset is system-wide, so WAIT_INIT re-synchronises.

Test Plan:
- Init gating: I_REQ=4'b0001 from reset; I_LCD_DONE pulse at cycle 500 -> no O_GNT before cycle 501; O_GNT=0001 at 502, O_LCD_START pulse at 503, O_LCD_WDATA0 equals I_MSG0[0].
- Single message: requester 2, line0 "HELLO" padded with spaces; done 2000 cycles after start -> O_ACK=0100 for one cycle, O_GNT=0 next cycle, O_BUSY low after HOLD_CYC (use 16).
- Round-robin: I_REQ=1111 held throughout -> grant order 0,1,2,3,0, each exactly once per rotation; no start during HOLD.
- Timeout: TIMEOUT_CYC=100, no I_LCD_DONE -> O_TIMEOUT=1 at 100 cycles after start, O_ACK pulse; next message completing with done -> O_TIMEOUT=0.
- Request withdrawn: I_REQ[1] dropped the cycle after grant -> start still pulses, ack[1] still pulses on done; late done arriving in IDLE causes no ack.
- Reset mid-BUSY: assert I_RST -> O_GNT=0, O_LCD_START=0, buffers all 8'h20, O_BUSY=1; requests ignored until the next I_LCD_DONE.
